// File: rtl/fp_pack_pipe_pkg.sv
// Shared widths, constants and the S1->S2 payload for the single-precision pack pipeline.
package fp_pack_pipe_pkg;

  localparam int SIZE_MAN_RESULT = 24;
  localparam int SIZE_EXP        = 9;
  localparam int SIZE_FRAC       = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  // exp_adj carries one extra bit so exp=511 plus a rounding carry cannot wrap.
  typedef struct packed {
    logic                 sign;
    logic [SIZE_EXP:0]    exp_adj;
    logic [SIZE_FRAC-1:0] frac;
    logic                 hidden;
    logic                 zero_flag;
    logic                 inf_flag;
    logic                 nan_flag;
  } s1_payload_t;

endpackage

// File: rtl/fp_pack_pipe_if.sv
// Valid/ready stream into the pack pipeline and the packed result stream out of it.
interface fp_pack_pipe_if;
  import fp_pack_pipe_pkg::*;

  logic                       i_valid;
  logic                       o_ready;
  logic                       i_sign;
  logic [SIZE_EXP-1:0]        i_exp;
  logic [SIZE_MAN_RESULT-1:0] i_man;
  logic                       i_ov_flow;
  logic                       i_zero_flag;
  logic                       i_inf_flag;
  logic                       i_nan_flag;
  logic                       o_valid;
  logic                       i_ready;
  logic [31:0]                o_result;
  logic                       o_overflow;
  logic                       o_underflow;

  modport slave (
    input  i_valid, i_sign, i_exp, i_man, i_ov_flow,
    input  i_zero_flag, i_inf_flag, i_nan_flag, i_ready,
    output o_ready, o_valid, o_result, o_overflow, o_underflow
  );

  modport master (
    output i_valid, i_sign, i_exp, i_man, i_ov_flow,
    output i_zero_flag, i_inf_flag, i_nan_flag, i_ready,
    input  o_ready, o_valid, o_result, o_overflow, o_underflow
  );

endinterface

// File: rtl/fp_pack_classify.sv
// Combinational special-case select and IEEE-754 single packing of an adjusted S1 payload.
module fp_pack_classify
  import fp_pack_pipe_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  s1_payload_t p,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  always_comb begin
    result    = {p.sign, 31'h0};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (p.nan_flag) begin
      result = CANON_NAN;
    end else if (p.inf_flag) begin
      result = {p.sign, EXP_MAX, {SIZE_FRAC{1'b0}}};
    end else if (p.zero_flag) begin
      result = {p.sign, 31'h0};
    end else if (p.exp_adj >= {2'b00, EXP_MAX}) begin
      result   = {p.sign, EXP_MAX, {SIZE_FRAC{1'b0}}};
      overflow = 1'b1;
    end else if ((p.exp_adj == '0) || !p.hidden) begin
      // denormals are flushed to signed zero
      underflow = 1'b1;
    end else begin
      result = {p.sign, p.exp_adj[7:0], p.frac};
    end
  end

endmodule

// File: rtl/fp_pack_pipe.sv
// Two-stage pack pipeline: S1 folds the rounding carry into the exponent, S2 classifies and packs.
module fp_pack_pipe
  import fp_pack_pipe_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fp_pack_pipe_if.slave bus
);

  logic        v1;
  logic        v2;
  logic        en1;
  logic        en2;
  s1_payload_t p1;
  s1_payload_t p1_next;
  logic [31:0] res2;
  logic        of2;
  logic        uf2;
  logic [31:0] cls_result;
  logic        cls_of;
  logic        cls_uf;

  // each stage advances when empty or when the stage after it drains
  assign en2         = !v2 || bus.i_ready;
  assign en1         = !v1 || en2;
  assign bus.o_ready = en1;

  always_comb begin
    p1_next           = '0;
    p1_next.sign      = bus.i_sign;
    p1_next.exp_adj   = {1'b0, bus.i_exp} + {{SIZE_EXP{1'b0}}, bus.i_ov_flow};
    p1_next.frac      = bus.i_ov_flow ? '0 : bus.i_man[SIZE_FRAC-1:0];
    p1_next.hidden    = bus.i_ov_flow || bus.i_man[SIZE_MAN_RESULT-1];
    p1_next.zero_flag = bus.i_zero_flag;
    p1_next.inf_flag  = bus.i_inf_flag;
    p1_next.nan_flag  = bus.i_nan_flag;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1 <= 1'b0;
      p1 <= '0;
    end else if (en1) begin
      v1 <= bus.i_valid;
      if (bus.i_valid) p1 <= p1_next;
    end
  end

  fp_pack_classify #(
    .CANON_NAN (CANON_NAN)
  ) u_classify (
    .p         (p1),
    .result    (cls_result),
    .overflow  (cls_of),
    .underflow (cls_uf)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v2   <= 1'b0;
      res2 <= 32'h0;
      of2  <= 1'b0;
      uf2  <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        res2 <= cls_result;
        of2  <= cls_of;
        uf2  <= cls_uf;
      end
    end
  end

  assign bus.o_valid     = v2;
  assign bus.o_result    = res2;
  assign bus.o_overflow  = of2;
  assign bus.o_underflow = uf2;

endmodule

// File: tb/tb_fp_pack_pipe.sv
// Self-checking bench for fp_pack_pipe: directed packing cases, randomized streams, back-pressure and reset.
module tb_fp_pack_pipe;

  localparam logic [31:0] CANON = 32'h7FC0_0000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fp_pack_pipe_if bus ();

  fp_pack_pipe #(
    .CANON_NAN (CANON)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [8:0]  e;
    logic [23:0] m;
    bit          ov, z, inf, nan;
    logic [31:0] r;
    bit          of, uf;
  } vec_t;

  // {overflow, underflow, result} from the packing rules in plain arithmetic
  function automatic logic [33:0] ref_pack(bit s, int e_in, logic [23:0] m, bit ov, bit z, bit inf, bit nan);
    int          e;
    logic [7:0]  e8;
    logic [22:0] f;
    e = e_in + (ov ? 1 : 0);
    if (nan) return {2'b00, CANON};
    if (inf) return {2'b00, s, 8'hFF, 23'h0};
    if (z) return {2'b00, s, 31'h0};
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e == 0 || !(ov || m[23])) return {2'b01, s, 31'h0};
    e8 = e[7:0];
    f  = ov ? 23'h0 : m[22:0];
    return {2'b00, s, e8, f};
  endfunction

  function automatic vec_t mk(bit s, logic [8:0] e, logic [23:0] m, bit ov, bit z, bit inf, bit nan,
                              logic [31:0] r, bit of, bit uf);
    vec_t v;
    v.s = s; v.e = e; v.m = m; v.ov = ov; v.z = z; v.inf = inf; v.nan = nan;
    v.r = r; v.of = of; v.uf = uf;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_sign = 0; bus.i_exp = '0; bus.i_man = '0; bus.i_ov_flow = 0;
    bus.i_zero_flag = 0; bus.i_inf_flag = 0; bus.i_nan_flag = 0;
  endtask

  task automatic randomize_fields();
    int pick;
    logic [8:0] edges [7];
    edges[0] = 9'd0; edges[1] = 9'd1; edges[2] = 9'd253; edges[3] = 9'd254;
    edges[4] = 9'd255; edges[5] = 9'd256; edges[6] = 9'd511;
    pick = $urandom_range(0, 3);
    bus.i_sign      = 1'($urandom_range(0, 1));
    bus.i_exp       = (pick == 0) ? edges[$urandom_range(0, 6)] : 9'($urandom_range(0, 511));
    bus.i_man       = 24'($urandom);
    bus.i_ov_flow   = ($urandom_range(0, 5) == 0);
    bus.i_zero_flag = ($urandom_range(0, 9) == 0);
    bus.i_inf_flag  = ($urandom_range(0, 9) == 0);
    bus.i_nan_flag  = ($urandom_range(0, 9) == 0);
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    bus.i_ready = 1;
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", bus.o_result); end
    checks++; if ({bus.o_overflow, bus.o_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", bus.o_overflow, bus.o_underflow); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    // offered item while reset is held must not be captured
    bus.i_valid = 1; bus.i_exp = 9'd127; bus.i_man = 24'h800000;
    @(negedge clk);
    rst = 0;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture cyc=%0d got=%b exp=0", k, bus.o_valid); end
    end
  endtask

  task automatic test_directed();
    vec_t tbl [14];
    tbl[0]  = mk(0, 9'd127, 24'hC00000, 0, 0, 0, 0, 32'h3FC00000, 0, 0);
    tbl[1]  = mk(0, 9'd127, 24'h000000, 1, 0, 0, 0, 32'h40000000, 0, 0);
    tbl[2]  = mk(1, 9'd254, 24'h000000, 1, 0, 0, 0, 32'hFF800000, 1, 0);
    tbl[3]  = mk(0, 9'd0,   24'h800000, 0, 0, 0, 0, 32'h00000000, 0, 1);
    tbl[4]  = mk(1, 9'd127, 24'h800000, 0, 1, 0, 0, 32'h80000000, 0, 0);
    tbl[5]  = mk(0, 9'd127, 24'h800000, 0, 0, 1, 1, 32'h7FC00000, 0, 0);
    tbl[6]  = mk(1, 9'd127, 24'h800000, 0, 0, 1, 0, 32'hFF800000, 0, 0);
    tbl[7]  = mk(0, 9'd300, 24'h800000, 0, 0, 0, 0, 32'h7F800000, 1, 0);
    tbl[8]  = mk(1, 9'd10,  24'h400000, 0, 0, 0, 0, 32'h80000000, 0, 1);
    tbl[9]  = mk(0, 9'd255, 24'h800000, 0, 0, 0, 0, 32'h7F800000, 1, 0);
    tbl[10] = mk(0, 9'd254, 24'hFFFFFF, 0, 0, 0, 0, 32'h7F7FFFFF, 0, 0);
    tbl[11] = mk(0, 9'd1,   24'h800000, 0, 0, 0, 0, 32'h00800000, 0, 0);
    tbl[12] = mk(0, 9'd511, 24'hFFFFFF, 1, 0, 0, 0, 32'h7F800000, 1, 0);
    tbl[13] = mk(0, 9'd0,   24'h123456, 1, 0, 0, 0, 32'h00800000, 0, 0);
    bus.i_ready = 1;
    for (int i = 0; i < 14; i++) begin
      bus.i_valid = 1; bus.i_sign = tbl[i].s; bus.i_exp = tbl[i].e; bus.i_man = tbl[i].m;
      bus.i_ov_flow = tbl[i].ov; bus.i_zero_flag = tbl[i].z; bus.i_inf_flag = tbl[i].inf; bus.i_nan_flag = tbl[i].nan;
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL dir_latency vec=%0d got=%b exp=0", i, bus.o_valid); end
      @(negedge clk);
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL dir_valid vec=%0d got=%b exp=1", i, bus.o_valid); end
      checks++; if (bus.o_result !== tbl[i].r) begin errors++; $display("FAIL dir_result vec=%0d got=%h exp=%h", i, bus.o_result, tbl[i].r); end
      checks++; if ({bus.o_overflow, bus.o_underflow} !== {tbl[i].of, tbl[i].uf}) begin
        errors++; $display("FAIL dir_flags vec=%0d got=%b%b exp=%b%b", i, bus.o_overflow, bus.o_underflow, tbl[i].of, tbl[i].uf);
      end
    end
    @(negedge clk);
  endtask

  // bp_mode: continuous input, i_ready dropped for 5 cycles starting 3 cycles after the first o_valid
  task automatic test_stream(input int n_items, input bit bp_mode);
    logic [33:0] q [$];
    int          ages [$];
    int          sent, got, cyc, first_v, ready_low;
    bit          exp_valid, exp_ready, push, pop;
    logic [33:0] r;
    sent = 0; got = 0; cyc = 0; first_v = -1; ready_low = 0;
    idle_inputs();
    bus.i_ready = 1;
    while ((sent < n_items || q.size() > 0) && cyc < 4000) begin
      randomize_fields();
      bus.i_valid = (sent < n_items) && (bp_mode || $urandom_range(0, 3) != 0);
      if (bp_mode) bus.i_ready = !(first_v >= 0 && cyc >= first_v + 3 && cyc < first_v + 8);
      else         bus.i_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_valid = (q.size() > 0) && (ages[0] >= 2);
      exp_ready = (q.size() < 2) || bus.i_ready;
      checks++; if (bus.o_valid !== exp_valid) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, bus.o_valid, exp_valid); end
      checks++; if (bus.o_ready !== exp_ready) begin errors++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, bus.o_ready, exp_ready); end
      if (exp_valid) begin
        checks++; if ({bus.o_overflow, bus.o_underflow, bus.o_result} !== q[0]) begin
          errors++; $display("FAIL stream_data cyc=%0d got=%b%b_%h exp=%b_%h", cyc, bus.o_overflow, bus.o_underflow, bus.o_result, q[0][33:32], q[0][31:0]);
        end
        if (first_v < 0) first_v = cyc;
      end
      if (!exp_ready) ready_low++;
      pop  = exp_valid && bus.i_ready;
      push = bus.i_valid && exp_ready;
      r = ref_pack(bus.i_sign, int'(bus.i_exp), bus.i_man, bus.i_ov_flow, bus.i_zero_flag, bus.i_inf_flag, bus.i_nan_flag);
      foreach (ages[k]) ages[k]++;
      if (pop) begin void'(q.pop_front()); void'(ages.pop_front()); got++; end
      if (push) begin q.push_back(r); ages.push_back(1); sent++; end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    bus.i_ready = 1;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stream_timeout left=%0d exp=0", q.size()); end
    checks++; if (got != n_items) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", got, n_items); end
    if (bp_mode && n_items >= 6) begin
      checks++; if (ready_low == 0) begin errors++; $display("FAIL stream_backpressure ready_low_cycles=%0d exp>0", ready_low); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL stream_dup cyc=%0d got=%b exp=0", k, bus.o_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    bus.i_ready = 0;
    bus.i_valid = 1; bus.i_exp = 9'd127; bus.i_man = 24'hC00000;
    @(negedge clk);
    bus.i_exp = 9'd130;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({bus.o_valid, bus.o_ready} !== 2'b10) begin errors++; $display("FAIL mid_full got=%b%b exp=10", bus.o_valid, bus.o_ready); end
    rst = 1;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", bus.o_valid); end
    checks++; if ({bus.o_overflow, bus.o_underflow, bus.o_result} !== 34'h0) begin
      errors++; $display("FAIL mid_rst_out got=%b%b_%h exp=00_00000000", bus.o_overflow, bus.o_underflow, bus.o_result);
    end
    @(negedge clk);
    rst = 0;
    bus.i_ready = 1;
    bus.i_valid = 1; bus.i_exp = 9'd128; bus.i_man = 24'h800000;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_cyc1_valid got=%b exp=0", bus.o_valid); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL mid_cyc2_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'h40000000) begin errors++; $display("FAIL mid_cyc2_result got=%h exp=40000000", bus.o_result); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got=%b exp=0", bus.o_valid); end
  endtask

  initial begin
    clk = 0;
    rst = 1;
    errors = 0;
    checks = 0;
    bus.i_ready = 1;
    idle_inputs();
    test_reset();
    test_directed();
    test_stream(4, 1'b1);
    test_stream(8, 1'b1);
    test_stream(300, 1'b0);
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_pack_pipe.md
FP_PACK_PIPE -- requirements
Module: fp_pack_pipe

Interface
REQ-001 SHALL have parameter CANON_NAN, default 32'h7FC0_0000, canonical quiet-NaN encoding emitted for any NaN result.
REQ-002 SHALL have port i_clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  upstream (rounding stage) data valid.
REQ-005 SHALL have port o_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port i_sign  input  1  result sign.
REQ-007 SHALL have port i_exp  input  9  biased exponent from normalizer, unsigned, 0..511.
REQ-008 SHALL have port i_man  input  24  rounded mantissa, hidden bit at [23].
REQ-009 SHALL have port i_ov_flow  input  1  rounding carry-out; mantissa wrapped to zero.
REQ-010 SHALL have ports i_zero_flag, i_inf_flag, i_nan_flag  input  1 each  special-operand class from front end.
REQ-011 SHALL have port o_valid  output  1  o_result valid.
REQ-012 SHALL have port i_ready  input  1  downstream accepts result.
REQ-013 SHALL have port o_result  output  32  IEEE-754 single-precision word.
REQ-014 SHALL have ports o_overflow, o_underflow  output  1 each  exception flags aligned with o_result.

Function
REQ-015 SHALL be a two-stage pipeline (S1 adjust, S2 classify/pack); latency exactly 2 cycles from accepted input to o_valid with no stall.
REQ-016 SHALL transfer on i_valid&o_ready at input and o_valid&i_ready at output.
REQ-017 SHALL compute en2 = !v2 | i_ready, en1 = !v1 | en2, o_ready = en1; full throughput of one item per cycle.
REQ-018 SHALL hold o_result, o_overflow, o_underflow stable while o_valid & !i_ready.
REQ-019 S1 SHALL form exp_adj (10 bits) = i_exp + i_ov_flow and frac = i_ov_flow ? 23'h0 : i_man[22:0]; hidden = i_ov_flow | i_man[23].
REQ-020 S2 SHALL select by priority: nan -> CANON_NAN; inf -> {sign,8'hFF,23'h0}; zero_flag -> {sign,31'h0}; exp_adj>=255 -> {sign,8'hFF,23'h0} with o_overflow=1; exp_adj==0 or hidden==0 -> {sign,31'h0} with o_underflow=1 (flush-to-zero); else {sign,exp_adj[7:0],frac}.
REQ-021 SHALL assert o_overflow/o_underflow only on the cases in REQ-020; both 0 for NaN, inf, zero_flag inputs.
REQ-022 SHALL preserve order; no item dropped or duplicated under any i_ready pattern.
REQ-023 SHALL ignore input fields when i_valid=0 or o_ready=0 (no state change of S1 payload).
REQ-024 With both stages full and i_ready=1, SHALL accept a new input the same cycle (simultaneous push/pop).

Reset
REQ-025 i_rst=1 SHALL immediately clear v1, v2; o_valid=0, o_result=32'h0, o_overflow=0, o_underflow=0.
REQ-026 During reset o_ready SHALL read 1 (en1 true) but no transfer is recorded; first post-reset accepted item appears 2 cycles later.
REQ-027 Reset mid-operation SHALL discard all in-flight items.

Structure
REQ-028 A shared package SHALL hold SIZE_MAN_RESULT=24, SIZE_EXP=9, SIZE_FRAC=23, EXP_MAX=8'hFF, and a packed struct for the S1->S2 payload (sign, exp_adj, frac, hidden, class flags).
REQ-029 SHALL instantiate one sub-module fp_pack_classify (combinational REQ-020 select), used inside S2.

Verification
REQ-030 sign=0, exp=127, man=24'hC00000, ov=0 -> 2 cycles later o_result=32'h3FC00000, flags 0.
REQ-031 sign=0, exp=127, man=24'h000000, ov=1 -> o_result=32'h40000000; exp=254, ov=1, sign=1 -> 32'hFF800000, o_overflow=1.
REQ-032 exp=0, man=24'h800000 -> 32'h00000000, o_underflow=1; zero_flag=1, sign=1 -> 32'h80000000, flags 0.
REQ-033 nan_flag=1 and inf_flag=1 together -> 32'h7FC00000; inf_flag only, sign=1 -> 32'hFF800000.
REQ-034 Stream 4 items, drop i_ready 3 cycles after first o_valid -> o_result held, o_ready=0 once both stages full, all 4 emerge in order, none duplicated.
REQ-035 Assert i_rst with v1=v2=1 -> o_valid=0 same cycle, outputs zero; after release, new item exp=128, man=24'h800000 -> 32'h40000000 at cycle 2.
